xtea_core: RTL and testbench
============================

# xtea_core

Iterative XTEA block-cipher engine (64-bit block, 128-bit key, 32 cycles) for the cipher library. It uses the same key-load / data-in / data-out pulse handshake as the existing 64-bit block cores, so the existing directed benches and system wrappers can drive it unchanged. Each accepted block is processed at one full XTEA cycle (two Feistel half-rounds) per clock.

## Interface
- No parameters. Constants: DELTA = 32'h9E37_79B9; decrypt initial sum = 32'hC6EF_3720.
- r_clk  input  1  clock; all logic on the rising edge.
- r_rst  input  1  reset, asynchronous, active-high.
- i_flag  input  1  1 = encrypt, 0 = decrypt; sampled with i_din_en.
- i_key  input  128  key; k[0]=i_key[127:96], k[1]=[95:64], k[2]=[63:32], k[3]=[31:0].
- i_key_en  input  1  one-cycle key-load strobe.
- i_din  input  64  input block; v0=i_din[63:32], v1=i_din[31:0].
- i_din_en  input  1  one-cycle block-start strobe.
- o_dout  output  64  result {v0,v1}; holds its value until the next result.
- o_dout_en  output  1  one-cycle result-valid pulse.
- o_key_ok  output  1  a key is loaded; blocks may be started.
- o_busy  output  1  a block is in progress.

## Operation
- States: IDLE, RUN. A 5-bit round counter and a 32-bit sum register track progress.
- Key load (IDLE only): when i_key_en=1, the key registers are written and o_key_ok is set to 1. o_key_ok stays 1 until reset.
- In RUN, i_key_en is ignored and the key is unchanged.
- Block start (IDLE, o_key_ok=1, i_din_en=1): capture v0, v1 and mode; set sum = 0 (encrypt) or 32'hC6EF_3720 (decrypt); set cnt = 0; go to RUN.
- i_din_en is ignored when o_key_ok=0 or in RUN. No queueing.
- If i_key_en and i_din_en are both 1 in IDLE: the key is loaded and the block is ignored.
- Encrypt cycle, all arithmetic mod 2^32:
  - v0 += (((v1<<4)^(v1>>5))+v1) ^ (sum + k[sum[1:0]])
  - s' = sum + DELTA
  - v1 += (((v0'<<4)^(v0'>>5))+v0') ^ (s' + k[s'[12:11]])
  - sum = s'
- Decrypt cycle (exact inverse):
  - v1 -= (((v0<<4)^(v0>>5))+v0) ^ (sum + k[sum[12:11]])
  - s' = sum - DELTA
  - v0 -= (((v1'<<4)^(v1'>>5))+v1') ^ (s' + k[s'[1:0]])
  - sum = s'
- Shifts are logical. v0'/v1' are the values updated within the same cycle, combinational in one clock.
- On the cycle where cnt==31: o_dout <= {v0_new, v1_new}, o_dout_en <= 1, return to IDLE. Otherwise cnt increments.
- Reset, including mid-block: state=IDLE, cnt=0, sum=0, v0=v1=0, key=0. Outputs: o_dout=64'h0, o_dout_en=0, o_key_ok=0, o_busy=0. An in-flight block is discarded and no o_dout_en is issued for it.

## Timing
- Edge E0 accepts the block: o_busy=1 from E0, and cycles run on edges E1..E32.
- At E32: o_dout_en=1 and o_busy=0, lasting one clock period.
- Latency: o_dout_en rises 32 clocks after the accepting edge.
- Back-to-back: i_din_en sampled at E33 (asserted while o_dout_en=1) is accepted. Throughput is one block per 33 clocks.
- o_key_ok rises on the edge that samples i_key_en=1. A block strobe on the following edge is accepted.
- o_dout_en is never high for two consecutive cycles.
- All outputs are registered with no combinational input-to-output paths.

## Test plan
- Key 128'h0, encrypt 64'h0 -> o_dout=64'hDEE9_D4D8_F713_1ED9. o_dout_en must be a single pulse 32 clocks after acceptance.
- Key 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F, encrypt 64'h4142_4344_4546_4748 -> 64'h497D_F3D0_7261_2CB5. Then decrypt that result -> 64'h4142_4344_4546_4748.
- Strobe i_din_en before any key load -> no o_busy, no o_dout_en for 40 clocks. o_key_ok stays 0.
- Pulse i_din_en and i_key_en (with a different key) at cycle 10 of a run -> both ignored, and the result still equals the first vector. Issue the next block on the cycle o_dout_en=1 -> it is accepted, and its result comes 33 clocks after the first result.
- Assert r_rst at cycle 15 of a run -> all outputs 0, and no o_dout_en after release. Reload the key and rerun -> correct ciphertext.
- Encrypt/decrypt loop of 8 iterations on one vector, mirroring the existing core bench -> error counter = 0.

Source files
------------

// File: rtl/xtea_core.sv
// Iterative XTEA engine: 64-bit block, 128-bit key, one full cycle
// (two Feistel half-rounds) per clock, 32 clocks per block.
module xtea_core (
   input  logic         r_clk,
   input  logic         r_rst,
   input  logic         i_flag,
   input  logic [127:0] i_key,
   input  logic         i_key_en,
   input  logic [63:0]  i_din,
   input  logic         i_din_en,
   output logic [63:0]  o_dout,
   output logic         o_dout_en,
   output logic         o_key_ok,
   output logic         o_busy
);

   localparam logic [31:0] DELTA = 32'h9E37_79B9;
   localparam logic [31:0] DSUM  = 32'hC6EF_3720;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [4:0]    r_cnt;
   logic [31:0]   r_sum;
   logic [31:0]   r_v0;
   logic [31:0]   r_v1;
   logic          r_mode;
   logic [127:0]  r_key;
   logic [63:0]   r_dout;
   logic          r_dout_en;
   logic          r_key_ok;

   logic          w_idle;
   logic          w_start;
   logic          w_last;
   logic [31:0]   w_e0;
   logic [31:0]   w_es;
   logic [31:0]   w_e1;
   logic [31:0]   w_d1;
   logic [31:0]   w_ds;
   logic [31:0]   w_d0;
   logic [31:0]   w_v0n;
   logic [31:0]   w_v1n;
   logic [31:0]   w_sn;

   function automatic logic [31:0] f_mix(input logic [31:0] x);
      return ((x << 4) ^ (x >> 5)) + x;
   endfunction

   function automatic logic [31:0] f_key(input logic [127:0] k,
                                         input logic [1:0]   i);
      logic [31:0] r;
      case (i)
         2'd0:    r = k[127:96];
         2'd1:    r = k[95:64];
         2'd2:    r = k[63:32];
         default: r = k[31:0];
      endcase
      return r;
   endfunction

   assign w_idle  = (r_state == S_IDLE);
   // a simultaneous key load wins over the block strobe
   assign w_start = w_idle & r_key_ok & i_din_en & ~i_key_en;
   assign w_last  = (r_state == S_RUN) & (r_cnt == 5'd31);

   assign w_e0 = r_v0 + (f_mix(r_v1) ^ (r_sum + f_key(r_key, r_sum[1:0])));
   assign w_es = r_sum + DELTA;
   assign w_e1 = r_v1 + (f_mix(w_e0) ^ (w_es + f_key(r_key, w_es[12:11])));

   assign w_d1 = r_v1 - (f_mix(r_v0) ^ (r_sum + f_key(r_key, r_sum[12:11])));
   assign w_ds = r_sum - DELTA;
   assign w_d0 = r_v0 - (f_mix(w_d1) ^ (w_ds + f_key(r_key, w_ds[1:0])));

   assign w_v0n = r_mode ? w_e0 : w_d0;
   assign w_v1n = r_mode ? w_e1 : w_d1;
   assign w_sn  = r_mode ? w_es : w_ds;

   always_ff @(posedge r_clk or posedge r_rst) begin
      if (r_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_start) w_next = S_RUN;
         S_RUN:  if (w_last)  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state == S_RUN);
   end

   always_ff @(posedge r_clk or posedge r_rst) begin
      if (r_rst) begin
         r_cnt     <= 5'd0;
         r_sum     <= 32'd0;
         r_v0      <= 32'd0;
         r_v1      <= 32'd0;
         r_mode    <= 1'b0;
         r_key     <= 128'd0;
         r_key_ok  <= 1'b0;
         r_dout    <= 64'd0;
         r_dout_en <= 1'b0;
      end else begin
         r_dout_en <= w_last;
         if (w_idle && i_key_en) begin
            r_key    <= i_key;
            r_key_ok <= 1'b1;
         end
         if (w_start) begin
            r_v0   <= i_din[63:32];
            r_v1   <= i_din[31:0];
            r_mode <= i_flag;
            r_sum  <= i_flag ? 32'd0 : DSUM;
            r_cnt  <= 5'd0;
         end else if (r_state == S_RUN) begin
            r_v0  <= w_v0n;
            r_v1  <= w_v1n;
            r_sum <= w_sn;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) r_dout <= {w_v0n, w_v1n};
         end
      end
   end

   assign o_dout    = r_dout;
   assign o_dout_en = r_dout_en;
   assign o_key_ok  = r_key_ok;

endmodule

// File: tb/tb_xtea_core.sv
// Directed bench for xtea_core: known vectors, strobe gating,
// back-to-back timing, mid-block reset and an enc/dec loop.
module tb_xtea_core;

   logic         r_clk = 1'b0;
   logic         r_rst;
   logic         i_flag;
   logic [127:0] i_key;
   logic         i_key_en;
   logic [63:0]  i_din;
   logic         i_din_en;
   logic [63:0]  o_dout;
   logic         o_dout_en;
   logic         o_key_ok;
   logic         o_busy;

   int n_asrt = 0;
   int n_fail = 0;

   localparam logic [127:0] K0 = 128'h0;
   localparam logic [127:0] K1 = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
   localparam logic [63:0]  P1 = 64'h4142_4344_4546_4748;
   localparam logic [63:0]  C1 = 64'h497D_F3D0_7261_2CB5;
   localparam logic [63:0]  C0 = 64'hDEE9_D4D8_F713_1ED9;

   xtea_core dut (
      .r_clk     (r_clk),
      .r_rst     (r_rst),
      .i_flag    (i_flag),
      .i_key     (i_key),
      .i_key_en  (i_key_en),
      .i_din     (i_din),
      .i_din_en  (i_din_en),
      .o_dout    (o_dout),
      .o_dout_en (o_dout_en),
      .o_key_ok  (o_key_ok),
      .o_busy    (o_busy)
   );

   always #5 r_clk = ~r_clk;

   task automatic tick();
      @(posedge r_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mix(input logic [31:0] x);
      return ((x << 4) ^ (x >> 5)) + x;
   endfunction

   // reference cipher in the textbook loop form
   function automatic logic [63:0] xref(input logic enc,
                                        input logic [127:0] key,
                                        input logic [63:0] blk);
      logic [31:0] k [4];
      logic [31:0] v0, v1, s;
      k[0] = key[127:96]; k[1] = key[95:64];
      k[2] = key[63:32];  k[3] = key[31:0];
      v0 = blk[63:32]; v1 = blk[31:0];
      s = enc ? 32'd0 : 32'hC6EF_3720;
      for (int r = 0; r < 32; r++) begin
         if (enc) begin
            v0 = v0 + (mix(v1) ^ (s + k[s[1:0]]));
            s  = s + 32'h9E37_79B9;
            v1 = v1 + (mix(v0) ^ (s + k[s[12:11]]));
         end else begin
            v1 = v1 - (mix(v0) ^ (s + k[s[12:11]]));
            s  = s - 32'h9E37_79B9;
            v0 = v0 - (mix(v1) ^ (s + k[s[1:0]]));
         end
      end
      return {v0, v1};
   endfunction

   task automatic load_key(input logic [127:0] k);
      i_key = k;
      i_key_en = 1'b1;
      tick();
      i_key_en = 1'b0;
      chk("key_ok", {63'd0, o_key_ok}, 64'd1);
   endtask

   // start a block; optionally inject junk strobes at run cycle inj;
   // returns with o_dout_en high (or after timeout)
   task automatic run_block(input string tag, input logic enc,
                            input logic [63:0] din, input int inj,
                            output logic [63:0] dout, output int lat);
      i_flag = enc;
      i_din = din;
      i_din_en = 1'b1;
      tick();
      i_din_en = 1'b0;
      chk({tag, "_busy"}, {63'd0, o_busy}, 64'd1);
      chk({tag, "_en_low"}, {63'd0, o_dout_en}, 64'd0);
      lat = 0;
      while (o_dout_en !== 1'b1 && lat < 40) begin
         if (lat == inj) begin
            i_din_en = 1'b1;
            i_key_en = 1'b1;
            i_key = ~i_key;
            i_din = ~din;
         end
         tick();
         lat++;
         i_din_en = 1'b0;
         i_key_en = 1'b0;
      end
      dout = o_dout;
      chk({tag, "_lat"}, 64'(lat), 64'd32);
      chk({tag, "_idle"}, {63'd0, o_busy}, 64'd0);
   endtask

   initial begin
      logic [63:0] res;
      logic [63:0] v;
      logic [63:0] c;
      int lat;
      int seen;
      int errcnt;

      r_rst = 1'b1;
      i_flag = 1'b0;
      i_key = '0;
      i_key_en = 1'b0;
      i_din = '0;
      i_din_en = 1'b0;
      tick();
      tick();
      chk("rst_dout", o_dout, 64'd0);
      chk("rst_flags", {61'd0, o_dout_en, o_key_ok, o_busy}, 64'd0);
      r_rst = 1'b0;
      tick();

      // block strobe with no key loaded
      i_flag = 1'b1;
      i_din = P1;
      i_din_en = 1'b1;
      tick();
      i_din_en = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (o_busy || o_dout_en || o_key_ok) seen++;
         tick();
      end
      chk("nokey_quiet", 64'(seen), 64'd0);

      // key and block strobes together: key loads, block ignored
      i_key = K0;
      i_key_en = 1'b1;
      i_din_en = 1'b1;
      tick();
      i_key_en = 1'b0;
      i_din_en = 1'b0;
      chk("both_keyok", {63'd0, o_key_ok}, 64'd1);
      chk("both_nobusy", {63'd0, o_busy}, 64'd0);

      run_block("zero", 1'b1, 64'd0, -1, res, lat);
      chk("zero_ct", res, C0);
      tick();
      chk("zero_pulse", {63'd0, o_dout_en}, 64'd0);

      // new key; junk strobes mid-run; back-to-back decrypt
      load_key(K1);
      run_block("k1enc", 1'b1, P1, 10, res, lat);
      chk("k1enc_ct", res, C1);
      i_key = K1;
      run_block("k1dec", 1'b0, C1, -1, res, lat);
      chk("k1dec_pt", res, P1);
      chk("b2b_gap", 64'(lat + 1), 64'd33);

      // reset at cycle 15 of a run
      i_flag = 1'b1;
      i_din = P1;
      i_din_en = 1'b1;
      tick();
      i_din_en = 1'b0;
      repeat (15) tick();
      r_rst = 1'b1;
      #1;
      chk("mrst_dout", o_dout, 64'd0);
      chk("mrst_flags", {61'd0, o_dout_en, o_key_ok, o_busy}, 64'd0);
      tick();
      r_rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (o_dout_en || o_busy) seen++;
         tick();
      end
      chk("mrst_quiet", 64'(seen), 64'd0);
      load_key(K1);
      run_block("rerun", 1'b1, P1, -1, res, lat);
      chk("rerun_ct", res, C1);
      tick();

      // encrypt/decrypt chain
      errcnt = 0;
      v = 64'h0123_4567_89AB_CDEF;
      for (int it = 0; it < 8; it++) begin
         run_block("loop_e", 1'b1, v, -1, c, lat);
         chk("loop_ct", c, xref(1'b1, K1, v));
         run_block("loop_d", 1'b0, c, -1, res, lat);
         if (res !== v) errcnt++;
         v = c;
      end
      chk("loop_err", 64'(errcnt), 64'd0);
      chk("ref_k1", xref(1'b1, K1, P1), C1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
